vga_stream_out: RTL and testbench

VGA_STREAM_OUT -- requirements
Module: vga_stream_out

---
 rtl/vga_stream_out.sv | 186 ++++++++++++++++++
 tb/tb_vga_stream_out.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_stream_out.sv
// VGA raster generator fed by an AXI-Stream pixel source, with frame lock/resync tracking.
// Optional underflow counter port is enabled by defining VGA_UNDERFLOW_CNT_EN.
module vga_stream_out #(
  parameter int COLOR_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 pix_tvalid,
  output logic                 pix_tready,
  input  logic [3*COLOR_W-1:0] pix_tdata,
  input  logic                 pix_tuser,
  input  logic                 pix_tlast,
  input  logic                 init,
  input  logic [CNT_W-1:0]     H_RES,
  input  logic [CNT_W-1:0]     H_FRONT_PORCH,
  input  logic [CNT_W-1:0]     H_SYNC_PULSE,
  input  logic [CNT_W-1:0]     H_BACK_PORCH,
  input  logic [CNT_W-1:0]     V_RES,
  input  logic [CNT_W-1:0]     V_FRONT_PORCH,
  input  logic [CNT_W-1:0]     V_SYNC_PULSE,
  input  logic [CNT_W-1:0]     V_BACK_PORCH,
  input  logic                 H_POL,
  input  logic                 V_POL,
  output logic                 vga_hsync,
  output logic                 vga_vsync,
  output logic                 vga_de,
  output logic [COLOR_W-1:0]   vga_r,
  output logic [COLOR_W-1:0]   vga_g,
  output logic [COLOR_W-1:0]   vga_b,
  output logic                 sof,
  output logic                 locked,
  output logic                 resync_err
`ifdef VGA_UNDERFLOW_CNT_EN
  , output logic [CNT_W-1:0]   underflow_cnt
`endif
);

  typedef enum logic [1:0] {S_SYNC, S_BP, S_ACT, S_FP} phase_t;

  function automatic logic [CNT_W-1:0] m1(input logic [CNT_W-1:0] x);
    return (x == '0) ? '0 : x - 1'b1;
  endfunction

  logic unused_tlast;
  assign unused_tlast = pix_tlast;

  // Shadow lengths stored as (field-1), indexed by phase_t
  logic [3:0][CNT_W-1:0] h_port, v_port, h_len, v_len;
  logic                  h_pol, v_pol;
  logic                  cap;

  assign cap    = !aresetn || init;
  assign h_port = {m1(H_FRONT_PORCH), m1(H_RES), m1(H_BACK_PORCH), m1(H_SYNC_PULSE)};
  assign v_port = {m1(V_FRONT_PORCH), m1(V_RES), m1(V_BACK_PORCH), m1(V_SYNC_PULSE)};

  always_ff @(posedge aclk) begin
    if (cap) begin
      h_len <= h_port;
      v_len <= v_port;
      h_pol <= H_POL;
      v_pol <= V_POL;
    end
  end

  phase_t           h_state, h_nxt, v_state, v_nxt;
  logic [CNT_W-1:0] hcnt, hcnt_nxt, vcnt, vcnt_nxt;
  logic             line_end;

  assign line_end = (h_state == S_FP) && (hcnt == '0);

  always_ff @(posedge aclk) begin
    h_state <= h_nxt;
    hcnt    <= hcnt_nxt;
    v_state <= v_nxt;
    vcnt    <= vcnt_nxt;
  end

  always_comb begin
    h_nxt    = h_state;
    hcnt_nxt = hcnt;
    v_nxt    = v_state;
    vcnt_nxt = vcnt;
    if (cap) begin
      h_nxt    = S_SYNC;
      hcnt_nxt = h_port[S_SYNC];
      v_nxt    = S_SYNC;
      vcnt_nxt = v_port[S_SYNC];
    end else begin
      if (hcnt == '0) begin
        h_nxt    = phase_t'(h_state + 2'd1);
        hcnt_nxt = h_len[h_nxt];
      end else begin
        hcnt_nxt = hcnt - 1'b1;
      end
      if (line_end) begin
        if (vcnt == '0) begin
          v_nxt    = phase_t'(v_state + 2'd1);
          vcnt_nxt = v_len[v_nxt];
        end else begin
          vcnt_nxt = vcnt - 1'b1;
        end
      end
    end
  end

  // Raster decode of the current cycle
  logic active, first_act, frame_start;
  assign active      = (h_state == S_ACT) && (v_state == S_ACT);
  assign first_act   = active && (hcnt == h_len[S_ACT]) && (vcnt == v_len[S_ACT]);
  assign frame_start = (h_state == S_SYNC) && (hcnt == h_len[S_SYNC]) &&
                       (v_state == S_SYNC) && (vcnt == v_len[S_SYNC]);

  // A misaligned tuser beat is already consumed, so it is parked here as the next-frame candidate
  logic                 cand_vld;
  logic [3*COLOR_W-1:0] cand_data;
  logic                 hold_bus, lock_now, take, show, err_user, err_first, resync, underflow;
  logic [3*COLOR_W-1:0] pix;

  assign hold_bus = pix_tvalid && pix_tuser;
  assign lock_now = !locked && first_act && (cand_vld || hold_bus);

  always_comb begin
    pix_tready = 1'b1;
    if (cap)           pix_tready = 1'b0;
    else if (locked)   pix_tready = active;
    else if (cand_vld) pix_tready = 1'b0;
    else if (hold_bus) pix_tready = first_act;
  end

  assign take      = pix_tvalid && pix_tready;
  assign show      = active && ((locked && pix_tvalid) || lock_now);
  assign pix       = cand_vld ? cand_data : pix_tdata;
  assign err_user  = locked && take && pix_tuser && !first_act;
  assign err_first = locked && first_act && pix_tvalid && !pix_tuser;
  assign resync    = err_user || err_first;
  assign underflow = active && locked && !pix_tvalid;

  always_ff @(posedge aclk) begin
    if (cap) begin
      locked   <= 1'b0;
      cand_vld <= 1'b0;
    end else begin
      locked <= locked ? !resync : lock_now;
      if (lock_now) begin
        cand_vld <= 1'b0;
      end else if (err_user) begin
        cand_vld  <= 1'b1;
        cand_data <= pix_tdata;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      vga_hsync  <= !H_POL;
      vga_vsync  <= !V_POL;
      vga_de     <= 1'b0;
      vga_r      <= '0;
      vga_g      <= '0;
      vga_b      <= '0;
      sof        <= 1'b0;
      resync_err <= 1'b0;
    end else begin
      vga_hsync  <= (h_state == S_SYNC) ? h_pol : !h_pol;
      vga_vsync  <= (v_state == S_SYNC) ? v_pol : !v_pol;
      vga_de     <= active;
      vga_r      <= show ? pix[COLOR_W-1:0]           : '0;
      vga_g      <= show ? pix[2*COLOR_W-1:COLOR_W]   : '0;
      vga_b      <= show ? pix[3*COLOR_W-1:2*COLOR_W] : '0;
      sof        <= frame_start;
      resync_err <= !init && resync;
    end
  end

`ifdef VGA_UNDERFLOW_CNT_EN
  always_ff @(posedge aclk) begin
    if (cap)                                underflow_cnt <= '0;
    else if (underflow && ~&underflow_cnt) underflow_cnt <= underflow_cnt + 1'b1;
  end
`else
  logic unused_underflow;
  assign unused_underflow = underflow;
`endif

endmodule

// File: tb/tb_vga_stream_out.sv
// Directed bench for vga_stream_out: raster timing, lock-in, underflow, resync, init, zero field.
module tb_vga_stream_out;
  localparam int CW = 4;
  localparam int NW = 16;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          pix_tvalid = 1'b0, pix_tuser = 1'b0, pix_tlast = 1'b0, init = 1'b0;
  logic          pix_tready;
  logic [3*CW-1:0] pix_tdata = '0;
  logic [NW-1:0] H_RES = 4, H_FRONT_PORCH = 1, H_SYNC_PULSE = 1, H_BACK_PORCH = 1;
  logic [NW-1:0] V_RES = 3, V_FRONT_PORCH = 1, V_SYNC_PULSE = 1, V_BACK_PORCH = 1;
  logic          H_POL = 1'b0, V_POL = 1'b0;
  logic          vga_hsync, vga_vsync, vga_de, sof, locked, resync_err;
  logic [CW-1:0] vga_r, vga_g, vga_b;
`ifdef VGA_UNDERFLOW_CNT_EN
  logic [NW-1:0] underflow_cnt;
`endif

  vga_stream_out #(.COLOR_W(CW), .CNT_W(NW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .pix_tvalid(pix_tvalid), .pix_tready(pix_tready), .pix_tdata(pix_tdata),
    .pix_tuser(pix_tuser), .pix_tlast(pix_tlast), .init(init),
    .H_RES(H_RES), .H_FRONT_PORCH(H_FRONT_PORCH), .H_SYNC_PULSE(H_SYNC_PULSE),
    .H_BACK_PORCH(H_BACK_PORCH), .V_RES(V_RES), .V_FRONT_PORCH(V_FRONT_PORCH),
    .V_SYNC_PULSE(V_SYNC_PULSE), .V_BACK_PORCH(V_BACK_PORCH),
    .H_POL(H_POL), .V_POL(V_POL),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_de(vga_de),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .sof(sof), .locked(locked), .resync_err(resync_err)
`ifdef VGA_UNDERFLOW_CNT_EN
    , .underflow_cnt(underflow_cnt)
`endif
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  bit acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One raster cycle: inputs already applied; outputs of that cycle are visible on return
  task automatic cyc();
    #1;
    acc = pix_tvalid && pix_tready;
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic beat(input logic v, input logic u, input logic [3*CW-1:0] d);
    pix_tvalid = v;
    pix_tuser  = u;
    pix_tdata  = d;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
  endtask

  function automatic logic [31:0] rgb();
    return 32'({vga_b, vga_g, vga_r});
  endfunction

  bit hs_a [84];
  bit vs_a [84];
  bit de_a [84];
  bit sf_a [84];
  int hl, vl, dc, sc, rs, ac;

  initial begin
    // ---------------- reset values ----------------
    do_reset();
    aresetn = 1'b0;
    @(negedge aclk);
    #1;
    chk("rst_hsync", 32'(vga_hsync), 1);
    chk("rst_vsync", 32'(vga_vsync), 1);
    chk("rst_de", 32'(vga_de), 0);
    chk("rst_tready", 32'(pix_tready), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_sof", 32'(sof), 0);
    chk("rst_resync", 32'(resync_err), 0);
    chk("rst_rgb", rgb(), 0);
    aresetn = 1'b1;

    // ---------------- raster timing, two frames ----------------
    beat(0, 0, '0);
    #1 chk("unlk_tready", 32'(pix_tready), 1);
    for (int n = 0; n < 84; n++) begin
      cyc();
      hs_a[n] = vga_hsync; vs_a[n] = vga_vsync; de_a[n] = vga_de; sf_a[n] = sof;
    end
    hl = 0; vl = 0; dc = 0; sc = 0;
    for (int n = 0; n < 42; n++) begin
      hl += int'(!hs_a[n]); vl += int'(!vs_a[n]); dc += int'(de_a[n]);
    end
    for (int n = 0; n < 84; n++) sc += int'(sf_a[n]);
    chk("hsync_low_cnt", 32'(hl), 6);
    chk("vsync_low_cnt", 32'(vl), 7);
    chk("de_cnt", 32'(dc), 12);
    chk("sof_cnt", 32'(sc), 2);
    chk("sof_0", 32'(sf_a[0]), 1);
    chk("sof_42", 32'(sf_a[42]), 1);
    chk("hs_0", 32'(hs_a[0]), 0);
    chk("hs_6", 32'(hs_a[6]), 1);
    chk("hs_7", 32'(hs_a[7]), 0);
    chk("de_15", 32'(de_a[15]), 0);
    chk("de_16", 32'(de_a[16]), 1);

    // ---------------- lock-in ----------------
    do_reset();
    for (int n = 0; n < 5; n++) begin
      beat(1, 0, 12'hABC);
      cyc();
      chk("junk_taken", 32'(acc), 1);
      chk("junk_rgb", rgb(), 0);
    end
    beat(1, 1, 12'h123);
    ac = 0;
    for (int n = 5; n < 16; n++) begin
      cyc();
      ac += int'(acc);
    end
    chk("hold_taken", 32'(ac), 0);
    chk("hold_locked", 32'(locked), 0);
    cyc();                                    // n=16, first active pixel
    chk("lock_taken", 32'(acc), 1);
    chk("lock_locked", 32'(locked), 1);
    chk("lock_de", 32'(vga_de), 1);
    chk("lock_rgb", rgb(), 32'h123);
    beat(1, 0, 12'h456);
    cyc();                                    // n=17
    chk("px17_rgb", rgb(), 32'h456);

    // ---------------- underflow ----------------
    beat(0, 0, '0);
    for (int n = 18; n < 20; n++) begin
      cyc();
      chk("uf_de", 32'(vga_de), 1);
      chk("uf_rgb", rgb(), 0);
      chk("uf_locked", 32'(locked), 1);
    end
    beat(1, 0, 12'h456);
    cyc();                                    // n=20, front porch
    chk("fp_taken", 32'(acc), 0);
`ifdef VGA_UNDERFLOW_CNT_EN
    chk("uf_cnt", 32'(underflow_cnt), 2);
`endif
    rs = 0;
    for (int n = 21; n < 58; n++) begin
      cyc();
      rs += int'(resync_err);
      if (n == 42) chk("sof_f1", 32'(sof), 1);
    end
    chk("f1_resync", 32'(rs), 0);
    chk("f1_locked", 32'(locked), 1);
    beat(1, 1, 12'h789);
    cyc();                                    // n=58, aligned frame start
    chk("f2_rgb", rgb(), 32'h789);
    chk("f2_locked", 32'(locked), 1);
    chk("f2_resync", 32'(resync_err), 0);

    // ---------------- misalignment ----------------
    beat(1, 0, 12'h456);
    for (int n = 59; n < 67; n++) cyc();
    beat(1, 1, 12'h0F0);
    cyc();                                    // n=67, pixel 2 of active line 1
    chk("mis_resync", 32'(resync_err), 1);
    chk("mis_locked", 32'(locked), 0);
    beat(1, 0, 12'h456);
    cyc();                                    // n=68
    chk("mis_pulse_end", 32'(resync_err), 0);
    ac = acc ? 1 : 0;
    rs = 0;
    for (int n = 69; n < 100; n++) begin
      cyc();
      ac += int'(acc);
      rs += int'(resync_err);
    end
    chk("cand_stall", 32'(ac), 0);
    chk("cand_resync", 32'(rs), 0);
    cyc();                                    // n=100, next frame start
    chk("relock_taken", 32'(acc), 0);
    chk("relock_locked", 32'(locked), 1);
    chk("relock_rgb", rgb(), 32'h0F0);
    cyc();                                    // n=101
    chk("relock_next", rgb(), 32'h456);

    // ---------------- init mid-frame ----------------
    beat(0, 0, '0);
    H_RES = 8;
    H_POL = 1'b1;
    init  = 1'b1;
    cyc();
    init = 1'b0;
    cyc();                                    // m=0
    chk("init_hsync0", 32'(vga_hsync), 1);
    chk("init_vsync0", 32'(vga_vsync), 0);
    chk("init_sof", 32'(sof), 1);
    chk("init_locked", 32'(locked), 0);
    cyc();                                    // m=1
    chk("init_hsync1", 32'(vga_hsync), 0);
    for (int m = 2; m < 11; m++) cyc();
    chk("init_hsync10", 32'(vga_hsync), 0);
    cyc();                                    // m=11
    chk("init_hsync11", 32'(vga_hsync), 1);

    // ---------------- zero sync field ----------------
    H_RES = 4;
    H_POL = 1'b0;
    H_SYNC_PULSE = 0;
    do_reset();
    for (int n = 0; n < 43; n++) begin
      cyc();
      hs_a[n] = vga_hsync; de_a[n] = vga_de; sf_a[n] = sof;
    end
    hl = 0; dc = 0;
    for (int n = 0; n < 42; n++) begin
      hl += int'(!hs_a[n]); dc += int'(de_a[n]);
    end
    chk("z_hsync_low", 32'(hl), 6);
    chk("z_de_cnt", 32'(dc), 12);
    chk("z_hs_1", 32'(hs_a[1]), 1);
    chk("z_hs_7", 32'(hs_a[7]), 0);
    chk("z_de_16", 32'(de_a[16]), 1);
    chk("z_sof_42", 32'(sf_a[42]), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
